// File: rtl/noc_traffic_node.sv
// noc_traffic_node: mesh NoC traffic generator (raster-walk destinations) and packet checker.
// Define NOC_TRAFFIC_RX_STALL_EN to throttle rx_ready from a 16-bit LFSR.
module noc_traffic_node #(
   parameter int unsigned ID_W     = 4,
   parameter int unsigned X_ID     = 0,
   parameter int unsigned Y_ID     = 0,
   parameter int unsigned MESH_X   = 4,
   parameter int unsigned MESH_Y   = 4,
   parameter int unsigned PKT_LEN  = 4,
   parameter int unsigned NUM_PKTS = 16,
   parameter int unsigned INJ_GAP  = 0
) (
   input  logic        noc_clk,
   input  logic        noc_rst,
   input  logic        send_start,
   output logic        busy,
   output logic        done,
   output logic [63:0] tx_flit,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [63:0] rx_flit,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [15:0] rx_pkt_cnt,
   output logic [15:0] err_cnt
);
   typedef enum logic [2:0] {IDLE, HEAD, BODY, GAP, DONE} tx_st_e;
   typedef enum logic {R_HEAD, R_BODY} rx_st_e;
   localparam logic [ID_W-1:0] XI = ID_W'(X_ID);
   localparam logic [ID_W-1:0] YI = ID_W'(Y_ID);
   localparam logic [ID_W-1:0] XM = ID_W'(MESH_X - 1);
   localparam logic [ID_W-1:0] YM = ID_W'(MESH_Y - 1);
   localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);
   localparam logic [15:0] LAST_SEQ = 16'(NUM_PKTS - 1);
   localparam logic [15:0] GAP_END  = 16'(INJ_GAP - 1);

   function automatic logic [2*ID_W-1:0] step(input logic [ID_W-1:0] x, input logic [ID_W-1:0] y);
      return (x == XM) ? {ID_W'(0), (y == YM) ? ID_W'(0) : ID_W'(y + 1'b1)} : {ID_W'(x + 1'b1), y};
   endfunction

   tx_st_e          tx_q, tx_d;
   logic [15:0]     seq_q, seq_d, idx_q, idx_d, gap_q, gap_d;
   logic [ID_W-1:0] dx_q, dx_d, dy_q, dy_d, hx, hy, nx, ny;
   logic            start, xfer, tail_xfer;

   always_ff @(posedge noc_clk or posedge noc_rst)
      if (noc_rst) begin
         tx_q  <= IDLE;
         seq_q <= '0;
         idx_q <= '0;
         gap_q <= '0;
         dx_q  <= '0;
         dy_q  <= '0;
      end else begin
         tx_q  <= tx_d;
         seq_q <= seq_d;
         idx_q <= idx_d;
         gap_q <= gap_d;
         dx_q  <= dx_d;
         dy_q  <= dy_d;
      end

   always_comb begin
      tx_d = tx_q;
      case (tx_q)
         IDLE, DONE: if (send_start) tx_d = HEAD;
         HEAD:       if (tx_ready) tx_d = BODY;
         BODY:       if (tx_ready && idx_q == LAST_IDX)
                        tx_d = (seq_q == LAST_SEQ) ? DONE : (INJ_GAP > 0) ? GAP : HEAD;
         GAP:        if (gap_q == GAP_END) tx_d = HEAD;
         default:    tx_d = IDLE;
      endcase
   end

   // The head destination skips our own node; the walk advances past it after the head goes out.
   always_comb begin
      {hx, hy}  = (dx_q == XI && dy_q == YI) ? step(dx_q, dy_q) : {dx_q, dy_q};
      {nx, ny}  = step(hx, hy);
      start     = (tx_q == IDLE || tx_q == DONE) && send_start;
      xfer      = tx_valid && tx_ready;
      tail_xfer = xfer && tx_q == BODY && idx_q == LAST_IDX;
      seq_d     = start ? 16'd0 : tail_xfer ? seq_q + 16'd1 : seq_q;
      idx_d     = (tx_q == HEAD) ? 16'd1 : (xfer && tx_q == BODY) ? idx_q + 16'd1 : idx_q;
      gap_d     = (tx_q == GAP) ? gap_q + 16'd1 : 16'd0;
      {dx_d, dy_d} = start ? '0 : (xfer && tx_q == HEAD) ? {nx, ny} : {dx_q, dy_q};
   end

   always_comb begin
      busy     = tx_q == HEAD || tx_q == BODY || tx_q == GAP;
      done     = tx_q == DONE;
      tx_valid = tx_q == HEAD || tx_q == BODY;
      tx_flit  = (tx_q == HEAD) ? {2'b00, 4'(hx), 4'(hy), 4'(XI), 4'(YI), seq_q, 30'd0} :
                 (tx_q == BODY) ? {(idx_q == LAST_IDX) ? 2'b10 : 2'b01, 30'd0, seq_q, idx_q} : 64'd0;
   end

   rx_st_e      rx_q, rx_d;
   logic [15:0] rseq_q, rseq_d, ridx_q, ridx_d, pkt_q, pkt_d, err_q, err_d;
   logic [1:0]  rtyp;
   logic        acc, bad, unused_src;

   assign unused_src = ^rx_flit[53:46];

   always_ff @(posedge noc_clk or posedge noc_rst)
      if (noc_rst) begin
         rx_q   <= R_HEAD;
         rseq_q <= '0;
         ridx_q <= '0;
         pkt_q  <= '0;
         err_q  <= '0;
      end else begin
         rx_q   <= rx_d;
         rseq_q <= rseq_d;
         ridx_q <= ridx_d;
         pkt_q  <= pkt_d;
         err_q  <= err_d;
      end

   // A head always opens a new packet, even when it also counts as an error.
   always_comb begin
      acc  = rx_valid && rx_ready;
      rtyp = rx_flit[63:62];
      bad  = (rtyp == 2'b00) ? (rx_q == R_BODY || rx_flit[61:58] != 4'(XI) || rx_flit[57:54] != 4'(YI)) :
             (rx_q == R_HEAD || rtyp == 2'b11 || rx_flit[31:16] != rseq_q || rx_flit[15:0] != ridx_q ||
              (rtyp == 2'b10 && rx_flit[15:0] != LAST_IDX));
      rx_d   = !acc ? rx_q : (rtyp == 2'b00) ? R_BODY : (rtyp == 2'b10 && rx_q == R_BODY) ? R_HEAD : rx_q;
      rseq_d = (acc && rtyp == 2'b00) ? rx_flit[45:30] : rseq_q;
      ridx_d = (acc && rtyp == 2'b00) ? 16'd1 :
               (acc && rtyp == 2'b01 && rx_q == R_BODY) ? ridx_q + 16'd1 : ridx_q;
      pkt_d  = (acc && rtyp == 2'b10 && rx_q == R_BODY && pkt_q != 16'hFFFF) ? pkt_q + 16'd1 : pkt_q;
      err_d  = (acc && bad && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
   end

   assign rx_pkt_cnt = pkt_q;
   assign err_cnt    = err_q;

`ifdef NOC_TRAFFIC_RX_STALL_EN
   logic [15:0] lfsr_q;
   always_ff @(posedge noc_clk or posedge noc_rst)
      if (noc_rst) lfsr_q <= 16'hACE1;
      else         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign rx_ready = lfsr_q[1:0] != 2'b00;
`else
   assign rx_ready = 1'b1;
`endif
endmodule
